// File: rtl/regfile_sb.sv
// regfile_sb: register file with pending scoreboard and sequenced clear engine
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pend,
  output logic            rs2_pend,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  output logic            alloc_stall,
  input  logic            clr_req,
  output logic            busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pend;
  logic [AW-1:0] idx;
  logic idle, wr_ok, alloc_ok, idx_last;
  assign idle = state == IDLE;
  assign busy = state == CLEAR;
  assign idx_last = idx == AW'(NREG - 1);
  assign wr_ok = wr_en & |wr_addr & idle;
  assign alloc_stall = alloc_en & |alloc_addr & pend[alloc_addr] & idle;
  assign alloc_ok = alloc_en & |alloc_addr & ~pend[alloc_addr] & idle;
  always_comb begin
    state_nx = state;
    if (idle && clr_req) state_nx = CLEAR;
    else if (busy && idx_last) state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      pend <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      if (busy) begin
        rf[idx] <= '0;
        idx <= idx_last ? idx : idx + AW'(1);
      end else begin
        if (wr_ok) rf[wr_addr] <= wr_data;
        if (clr_req) begin
          pend <= '0;
          idx <= AW'(1);
        end else begin
          if (wr_ok) pend[wr_addr] <= 1'b0;
          if (alloc_ok) pend[alloc_addr] <= 1'b1;
        end
      end
    end
`ifdef RF_BYPASS_EN
  logic fwd1, fwd2, fwd_pend;
  assign fwd1 = wr_ok && rs1_addr == wr_addr;
  assign fwd2 = wr_ok && rs2_addr == wr_addr;
  assign fwd_pend = alloc_ok && alloc_addr == wr_addr;
  assign rs1_data = fwd1 ? wr_data : rf[rs1_addr];
  assign rs2_data = fwd2 ? wr_data : rf[rs2_addr];
  assign rs1_pend = fwd1 ? fwd_pend : pend[rs1_addr];
  assign rs2_pend = fwd2 ? fwd_pend : pend[rs2_addr];
`else
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];
  assign rs1_pend = pend[rs1_addr];
  assign rs2_pend = pend[rs2_addr];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb
module tb_regfile_sb;
  logic clock = 0;
  logic reset_n = 0;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, wr_addr = 0, alloc_addr = 0;
  logic [31:0] rs1_data, rs2_data, wr_data = 0;
  logic rs1_pend, rs2_pend, wr_en = 0, alloc_en = 0, alloc_stall, clr_req = 0, busy;
  int n_cmp = 0, n_bad = 0, cnt;
  regfile_sb dut (
    .clock(clock), .reset_n(reset_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_stall(alloc_stall),
    .clr_req(clr_req), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    alloc_en = 1;
    alloc_addr = 5;
    rs1_addr = 5;
    #1;
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_rs2_data", rs2_data, 0);
    chk("rst_pend", {rs1_pend, rs2_pend}, 0);
    chk("rst_stall", alloc_stall, 0);
    chk("rst_busy", busy, 0);
    alloc_en = 0;
    step();
    reset_n = 1;
    step();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    rs1_addr = 5; rs2_addr = 5;
    step();
    chk("x5_rs1", rs1_data, 32'hDEADBEEF);
    chk("x5_rs2", rs2_data, 32'hDEADBEEF);
    wr_addr = 0; wr_data = 32'h1234; rs1_addr = 0;
    step();
    chk("x0_zero", rs1_data, 0);
    wr_en = 0;
    alloc_en = 1; alloc_addr = 7; rs1_addr = 7;
    #1;
    chk("alloc7_nostall", alloc_stall, 0);
    step();
    chk("x7_pend", rs1_pend, 1);
    chk("x7_stall", alloc_stall, 1);
    step();
    chk("x7_pend_kept", rs1_pend, 1);
    alloc_en = 0;
    wr_en = 1; wr_addr = 7; wr_data = 32'h55;
    step();
    chk("x7_pend_clr", rs1_pend, 0);
    chk("x7_data", rs1_data, 32'h55);
    alloc_en = 1; alloc_addr = 9; wr_addr = 9; wr_data = 32'hA5; rs1_addr = 9;
    step();
    chk("x9_data", rs1_data, 32'hA5);
    chk("x9_pend", rs1_pend, 1);
    alloc_addr = 3; wr_addr = 4; wr_data = 32'h44; rs1_addr = 3; rs2_addr = 4;
    step();
    chk("x3_pend", rs1_pend, 1);
    chk("x4_pend", rs2_pend, 0);
    chk("x4_data", rs2_data, 32'h44);
    alloc_en = 0;
    wr_addr = 12; wr_data = 32'h77; rs1_addr = 12;
    #1;
`ifdef RF_BYPASS_EN
    chk("x12_bypass", rs1_data, 32'h77);
`else
    chk("x12_nobypass", rs1_data, 0);
`endif
    step();
    chk("x12_after", rs1_data, 32'h77);
    for (int i = 1; i < 32; i++) begin
      wr_addr = 5'(i);
      wr_data = 32'h1000 + i;
      step();
    end
    wr_en = 0;
    alloc_en = 1; alloc_addr = 20; rs1_addr = 31; rs2_addr = 20;
    step();
    chk("x31_loaded", rs1_data, 32'h101F);
    chk("x20_pend_pre", rs2_pend, 1);
    alloc_en = 0;
    clr_req = 1;
    step();
    clr_req = 0;
    wr_en = 1; wr_addr = 6; wr_data = 32'hFF;
    alloc_en = 1; alloc_addr = 10;
    #1;
    chk("busy_stall", alloc_stall, 0);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      step();
    end
    wr_en = 0; alloc_en = 0;
    chk("busy_cycles", cnt, 31);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #1;
      chk("clr_data", rs1_data, 0);
      chk("clr_pend", rs1_pend, 0);
    end
    @(posedge clock);
    #1;
    wr_en = 1; wr_addr = 6; wr_data = 32'h66; rs1_addr = 6;
    step();
    wr_en = 0;
    chk("post_clr_wr", rs1_data, 32'h66);
    wr_en = 1; wr_addr = 31; wr_data = 32'hCAFE; rs1_addr = 31;
    step();
    wr_en = 0;
    chk("x31_reload", rs1_data, 32'hCAFE);
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (10) step();
    chk("mid_clr_busy", busy, 1);
    reset_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_data", rs1_data, 0);
    chk("abort_x6", rs2_data, rs2_addr == 6 ? 0 : rs2_data);
    step();
    reset_n = 1;
    step();
    chk("release_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
